// File: rtl/fb_flip_pkg.sv
// Purpose: shared register map, STATUS bit positions and types for the framebuffer flip controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_flip_pkg;

  // Register word offsets
  localparam logic [3:0] ADDR_CTRL      = 4'h0;
  localparam logic [3:0] ADDR_STATUS    = 4'h1;
  localparam logic [3:0] ADDR_FLIP      = 4'h2;
  localparam logic [3:0] ADDR_FRAME_CNT = 4'h3;
  localparam logic [3:0] ADDR_DROP_CNT  = 4'h4;
  localparam logic [3:0] ADDR_BASE0     = 4'h8;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  // STATUS bit positions
  localparam int ST_PENDING  = 0;
  localparam int ST_DISP_LSB = 2;
  localparam int ST_PEND_LSB = 4;
  localparam int ST_IRQ_FLAG = 8;
  localparam int ST_IDX_ERR  = 9;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } fsm_t;

endpackage

// File: rtl/vsync_edge.sv
// Purpose: 2-FF synchronizer for the asynchronous active-low vsync plus a falling-edge detector.
// Latency: edge_pulse is high in the cycle after the 2nd clk edge that samples vsync low.
// Backpressure: none; the pulse is one cycle wide and cannot be stalled.
// Ports: clk/reset (sync, active-high), vsync (async input), fall_pulse (one-cycle pulse out).
module vsync_edge (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic fall_pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Reset to the idle-high level so coming out of reset never fakes a falling edge
  // while vsync is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= vsync;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall_pulse = prev & ~sync2;

endmodule

// File: rtl/fb_flip_ctrl.sv
// Purpose: vsync-locked framebuffer flip controller with Avalon-MM register slave, frame/drop counters and irq.
// Latency: reads return 1 cycle after avs_read; fb_base/irq update on the 3rd clk edge after vsync is sampled low.
// Backpressure: none; no waitrequest, every access completes in one cycle.
// Ports: clk/reset; avs_* Avalon-MM slave; vsync (async, active-low); fb_base to pixel reader; irq level output.
module fb_flip_ctrl
  import fb_flip_pkg::*;
#(
  parameter int NUM_BUFS = 3,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  input  logic              vsync,
  output logic [ADDR_W-1:0] fb_base,
  output logic              irq
);

  logic              edge_pulse;
  logic              ctrl_en;
  logic              ctrl_irq_en;
  fsm_t              state_q;
  fsm_t              state_n;
  idx_t              pend_idx_q;
  idx_t              pend_idx_n;
  idx_t              disp_idx_q;
  idx_t              disp_idx_n;
  logic              drop_inc;
  logic              irq_flag_q;
  logic              idx_err_q;
  logic [31:0]       frame_cnt_q;
  logic [15:0]       drop_cnt_q;
  logic [ADDR_W-1:0] base_q [4];
  logic [ADDR_W-1:0] fb_base_q;
  logic [31:0]       rd_mux;
  logic [31:0]       readdata_q;

  vsync_edge u_vsync_edge (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .fall_pulse (edge_pulse)
  );

  // Write decode
  idx_t              wr_idx;
  logic              idx_legal;
  logic              wr_flip;
  logic              flip_ok;
  logic              flip_bad;
  logic              wr_ctrl;
  logic              wr_status;
  logic              base_sel;
  logic              frame_tick;
  logic              commit;
  logic [ADDR_W-1:0] base_wr;

  assign wr_idx     = avs_writedata[1:0];
  assign idx_legal  = int'(wr_idx) < NUM_BUFS;
  assign wr_flip    = avs_write && (avs_address == ADDR_FLIP);
  assign flip_ok    = wr_flip && idx_legal;
  assign flip_bad   = wr_flip && !idx_legal;
  assign wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
  assign wr_status  = avs_write && (avs_address == ADDR_STATUS);
  assign base_sel   = (avs_address[3:2] == ADDR_BASE0[3:2]) && (int'(avs_address[1:0]) < NUM_BUFS);
  assign base_wr    = ADDR_W'(avs_writedata) & ~ADDR_W'(3);
  assign frame_tick = edge_pulse && ctrl_en;
  // A commit always sees the pre-write FSM state; a FLIP write in the same
  // cycle is applied on top of the post-commit state.
  assign commit     = frame_tick && (state_q == PEND);

  // Flip request FSM: next state, pending/displayed index, drop event
  always_comb begin
    state_n    = state_q;
    pend_idx_n = pend_idx_q;
    disp_idx_n = disp_idx_q;
    drop_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flip_ok) begin
          state_n    = PEND;
          pend_idx_n = wr_idx;
        end
      end
      PEND: begin
        if (commit) begin
          disp_idx_n = pend_idx_q;
          if (flip_ok) begin
            // Committed request was not superseded; the new one starts fresh.
            pend_idx_n = wr_idx;
          end else begin
            state_n    = IDLE;
            pend_idx_n = '0;
          end
        end else if (flip_ok) begin
          pend_idx_n = wr_idx;
          drop_inc   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_idx_q  <= '0;
      disp_idx_q  <= '0;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      irq_flag_q  <= 1'b0;
      idx_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      fb_base_q   <= '0;
      readdata_q  <= '0;
      for (int i = 0; i < 4; i++) base_q[i] <= '0;
    end else begin
      state_q    <= state_n;
      pend_idx_q <= pend_idx_n;
      disp_idx_q <= disp_idx_n;

      if (wr_ctrl) begin
        ctrl_en     <= avs_writedata[CTRL_EN];
        ctrl_irq_en <= avs_writedata[CTRL_IRQ_EN];
      end

      // Set beats W1C when both land in the same cycle.
      if (commit)
        irq_flag_q <= 1'b1;
      else if (wr_status && avs_writedata[ST_IRQ_FLAG])
        irq_flag_q <= 1'b0;

      if (flip_bad)
        idx_err_q <= 1'b1;
      else if (wr_status && avs_writedata[ST_IDX_ERR])
        idx_err_q <= 1'b0;

      // fb_base is refreshed on every enabled frame edge, so BASE writes only
      // ever reach the reader at a frame boundary.
      if (frame_tick) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
        fb_base_q   <= base_q[disp_idx_n];
      end

      if (drop_inc && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;

      if (avs_write && base_sel)
        base_q[avs_address[1:0]] <= base_wr;

      if (avs_read)
        readdata_q <= rd_mux;
    end
  end

  // Read mux
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_CTRL: begin
        rd_mux[CTRL_EN]     = ctrl_en;
        rd_mux[CTRL_IRQ_EN] = ctrl_irq_en;
      end
      ADDR_STATUS: begin
        rd_mux[ST_PENDING]          = (state_q == PEND);
        rd_mux[ST_DISP_LSB +: 2]    = disp_idx_q;
        rd_mux[ST_PEND_LSB +: 2]    = pend_idx_q;
        rd_mux[ST_IRQ_FLAG]         = irq_flag_q;
        rd_mux[ST_IDX_ERR]          = idx_err_q;
      end
      ADDR_FRAME_CNT: rd_mux = frame_cnt_q;
      ADDR_DROP_CNT:  rd_mux = {16'h0000, drop_cnt_q};
      default: begin
        if (base_sel)
          rd_mux = 32'(base_q[avs_address[1:0]]);
      end
    endcase
  end

  assign avs_readdata = readdata_q;
  assign fb_base      = fb_base_q;
  assign irq          = irq_flag_q & ctrl_irq_en;

endmodule
